// File: rtl/pipelined_rca.sv
// pipelined_rca: pipelined ripple-carry adder/subtractor with valid/ready handshakes
module pipelined_rca #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             Carry,
   input  logic             Sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf
);
   localparam int CHUNK = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;
   localparam int YS    = (STAGES > 1) ? STAGES - 1 : 1;

   logic [STAGES-1:0]            valid_q, valid_d, carry_q, carry_d, rdy, sv, sc;
   logic [STAGES-1:0][WIDTH-1:0] acc_q, acc_d, sa, sb;
   logic [YS-1:0][WIDTH-1:0]     yeff_q, yeff_d;
   logic                         ovf_q, ovf_d, all_v;
   logic [WIDTH-1:0]             na;
   logic [CHUNK:0]               t;

   // Stage sources: raw operands (Y inverted for subtract) into stage 0, previous stage registers after
   always_comb begin
      sv[0] = in_valid;
      sa[0] = X;
      sb[0] = Sub ? ~Y : Y;
      sc[0] = Sub ? ~Carry : Carry;
      for (int k = 1; k < STAGES; k++) begin
         sv[k] = valid_q[k-1];
         sa[k] = acc_q[k-1];
         sb[k] = yeff_q[k-1];
         sc[k] = carry_q[k-1];
      end
   end

   // A stage is ready unless it and every stage after it are full with the output stalled
   always_comb begin
      all_v = 1'b1;
      for (int k = LAST; k >= 0; k--) begin
         all_v  = all_v & valid_q[k];
         rdy[k] = out_ready | ~all_v;
      end
   end

   // Each stage ripples its own chunk into the word; the upper chunk of acc still holds X, so the sign bits are available for Ovf at the last stage
   always_comb begin
      valid_d = valid_q;
      acc_d   = acc_q;
      yeff_d  = yeff_q;
      carry_d = carry_q;
      t       = '0;
      na      = '0;
      for (int k = 0; k < STAGES; k++) begin
         t  = {1'b0, sa[k][k*CHUNK +: CHUNK]} + {1'b0, sb[k][k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, sc[k]};
         na = sa[k];
         na[k*CHUNK +: CHUNK] = t[CHUNK-1:0];
         if (rdy[k]) begin
            valid_d[k] = sv[k];
            acc_d[k]   = na;
            carry_d[k] = t[CHUNK];
         end
      end
      for (int k = 0; k < LAST; k++)
         if (rdy[k]) yeff_d[k] = sb[k];
      ovf_d = rdy[LAST] ? (sa[LAST][WIDTH-1] == sb[LAST][WIDTH-1]) && (acc_d[LAST][WIDTH-1] != sa[LAST][WIDTH-1]) : ovf_q;
   end

   // Pipeline registers; reset discards every in-flight word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         acc_q   <= '0;
         yeff_q  <= '0;
         carry_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         acc_q   <= acc_d;
         yeff_q  <= yeff_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = valid_q[LAST];
   assign Sum       = acc_q[LAST];
   assign Cout      = carry_q[LAST];
   assign Ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_rca.sv
// tb_pipelined_rca: directed and random checks of the pipelined adder against an arithmetic model
module tb_pipelined_rca;
   logic        clk = 0, rst_n = 0, in_valid = 0, Carry = 0, Sub = 0, out_ready = 1;
   logic        in_ready, out_valid, Cout, Ovf;
   logic [15:0] X = 0, Y = 0, Sum;
   int          nchk = 0, npass = 0, nfail = 0, nacc = 0;
   logic [17:0] q[$];
   logic        held = 0, acc = 0;
   logic [18:0] prev = '0;

   pipelined_rca #(.WIDTH(16), .STAGES(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .X(X), .Y(Y), .Carry(Carry), .Sub(Sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
   );

   always #5 clk = ~clk;

   // {Cout, Sum, Ovf} from integer arithmetic on the operands
   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
      int r, t;
      r = s ? int'(x) - int'(y) - int'(c) : int'(x) + int'(y) + int'(c);
      t = s ? int'($signed(x)) - int'($signed(y)) - int'(c) : int'($signed(x)) + int'($signed(y)) + int'(c);
      return {s ? (r >= 0) : (r > 65535), r[15:0], (t > 32767) || (t < -32768)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive at the falling edge, then score both handshakes before the rising edge
   task automatic drive(input logic iv, input logic [15:0] x, input logic [15:0] y, input logic c, input logic s, input logic ordy);
      @(negedge clk);
      in_valid = iv; X = x; Y = y; Carry = c; Sub = s; out_ready = ordy;
      #1;
      if (held) chk("hold", {out_valid, Cout, Sum, Ovf}, prev);
      if (out_valid && out_ready) begin
         chk("nonempty", 32'(q.size() != 0), 1);
         if (q.size() != 0) chk("result", {Cout, Sum, Ovf}, q.pop_front());
      end
      acc = in_valid && in_ready;
      if (acc) q.push_back(model(x, y, c, s));
      held = out_valid && !out_ready;
      prev = {out_valid, Cout, Sum, Ovf};
   endtask

   task automatic idle(input logic ordy);
      drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), ordy);
   endtask

   task automatic send_wait(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s, input logic [17:0] e);
      drive(1'b1, x, y, c, s, 1'b1);
      chk("sw_accept", acc, 1);
      for (int n = 0; n < 3; n++) begin
         idle(1'b1);
         chk("sw_latency", out_valid, 0);
      end
      idle(1'b1);
      chk("sw_out_valid", out_valid, 1);
      chk("sw_result", {Cout, Sum, Ovf}, e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_outputs", {Cout, Sum, Ovf}, 0);
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1;
      // full carry ripple and overflow corners
      send_wait(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 16'h0000, 1'b0});
      send_wait(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 16'h8000, 1'b1});
      send_wait(16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 16'hFFFE, 1'b0});
      send_wait(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 16'h7FFF, 1'b1});
      // back-to-back throughput
      for (int n = 0; n < 12; n++) begin
         if (n < 8) begin
            drive(1'b1, 16'(n + 1), 16'((n + 1) * 256), 1'b0, 1'b0, 1'b1);
            chk("tp_in_ready", in_ready, 1);
         end else idle(1'b1);
         chk("tp_out_valid", out_valid, 32'(n >= 4));
         if (n >= 4) chk("tp_sum", Sum, 32'((n - 3) * 257));
      end
      // sustained backpressure fills exactly four words
      nacc = 0;
      for (int n = 0; n < 8; n++) begin
         drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
         nacc += int'(acc);
      end
      chk("bp_accepts", nacc, 4);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_head", {Cout, Sum, Ovf}, q[0]);
      drive(1'b1, 16'h4321, 16'h1234, 1'b1, 1'b0, 1'b1);
      chk("bp_swap_in_ready", in_ready, 1);
      chk("bp_swap_accept", acc, 1);
      for (int n = 0; n < 20 && q.size() != 0; n++) idle(1'b1);
      chk("bp_drained", q.size(), 0);
      // bubble collapsing under stall
      for (int n = 0; n < 10; n++) begin
         if (n == 0 || n == 3) begin
            drive(1'b1, 16'(16'h1000 * (n + 1)), 16'h0ABC, 1'b0, 1'b0, 1'b0);
            chk("bub_accept", acc, 1);
         end else idle(1'b0);
      end
      chk("bub_in_ready", in_ready, 1);
      chk("bub_out_valid", out_valid, 1);
      idle(1'b1);
      idle(1'b1);
      chk("bub_second", out_valid, 1);
      chk("bub_popped", q.size(), 0);
      idle(1'b1);
      chk("bub_empty", out_valid, 0);
      // asynchronous reset with words in flight
      drive(1'b1, 16'hF0F0, 16'h0F0F, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      chk("rf_loaded", out_valid, 1);
      #2 rst_n = 0;
      #1;
      chk("rf_out_valid", out_valid, 0);
      chk("rf_outputs", {Cout, Sum, Ovf}, 0);
      chk("rf_in_ready", in_ready, 1);
      q.delete();
      held = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      for (int n = 0; n < 3; n++) begin
         idle(1'b1);
         chk("rf_no_old", out_valid, 0);
      end
      send_wait(16'h1234, 16'h1111, 1'b0, 1'b0, {1'b0, 16'h2345, 1'b0});
      // random traffic against the scoreboard
      for (int n = 0; n < 300; n++)
         drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
      for (int n = 0; n < 20 && q.size() != 0; n++) idle(1'b1);
      chk("rand_drained", q.size(), 0);
      idle(1'b1);
      chk("rand_idle", out_valid, 0);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
